// File: rtl/chan_pkg.sv
// Shared defaults and types for the channel capture array.
package chan_pkg;

    localparam int N_CH_DEFAULT  = 8;
    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef logic [$clog2(N_CH_DEFAULT)-1:0] chan_idx_t;

endpackage

// File: rtl/chan_if.sv
// One producer channel: valid/data from the source, ready back from the sink.
interface chan_if #(
    parameter int WIDTH = 8
);
    timeunit 1ns;
    timeprecision 1ps;

    // A word transfers on a rising edge where valid && ready; the source holds
    // data stable while valid is high, and ready never depends on valid.
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport source (output valid, output data, input ready);
    modport sink   (input valid, input data, output ready);

endinterface

// File: rtl/chan_fifo.sv
// Single-channel circular buffer with registered count and synchronous flush.
module chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_data  = mem[rd_ptr];

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/chan_capture_array.sv
// Buffers N_CH producer channels and merges them round-robin onto one
// registered valid/ready stream tagged with the source channel index.
module chan_capture_array
    import chan_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    chan_if.sink                    u_chan [N_CH-1:0],
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [$clog2(N_CH)-1:0] o_chan,
    output logic [N_CH-1:0]         o_empty
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CW = $clog2(N_CH);

    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  empty;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  chan_rdy;
    logic [WIDTH-1:0] fifo_data [N_CH];
    logic [CW-1:0]    rr;
    logic [CW-1:0]    win;
    logic [CW:0]      scan;
    logic             found;
    logic             load;

    // Ready comes from registered count only, so a full FIFO refuses a push
    // even in the cycle it pops.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        assign chan_rdy[i]     = i_rst_n && !full[i] && !i_flush;
        assign u_chan[i].ready = chan_rdy[i];
        assign push[i]         = u_chan[i].valid && chan_rdy[i];

        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_flush (i_flush),
            .i_push  (push[i]),
            .i_data  (u_chan[i].data),
            .i_pop   (pop[i]),
            .o_data  (fifo_data[i]),
            .o_full  (full[i]),
            .o_empty (empty[i])
        );
    end

    assign o_empty = empty;
    assign load    = !o_valid || i_ready;

    // First non-empty channel at or after rr, wrapping mod N_CH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan = {1'b0, rr} + (CW+1)'(k);
            if (scan >= (CW+1)'(N_CH)) begin
                scan = scan - (CW+1)'(N_CH);
            end
            if (!found && !empty[scan[CW-1:0]]) begin
                found = 1'b1;
                win   = scan[CW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && found && !i_flush) begin
            pop[win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
            rr      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            rr      <= '0;
        end else if (load) begin
            o_valid <= found;
            if (found) begin
                o_data <= fifo_data[win];
                o_chan <= win;
                rr     <= (win == CW'(N_CH-1)) ? '0 : win + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chan_capture_array.sv
// Bench for chan_capture_array: directed scenarios plus a randomized run,
// all compared against a queue-based model of the channel buffers.
module tb_chan_capture_array;
  timeunit 1ns;
  timeprecision 1ps;
  import chan_pkg::*;

  localparam int N_CH  = N_CH_DEFAULT;
  localparam int WIDTH = WIDTH_DEFAULT;
  localparam int DEPTH = DEPTH_DEFAULT;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_flush;
  logic i_ready;
  logic o_valid;
  logic [WIDTH-1:0] o_data;
  chan_idx_t o_chan;
  logic [N_CH-1:0] o_empty;

  logic [N_CH-1:0] ch_valid;
  logic [N_CH-1:0] ch_rdy;
  logic [WIDTH-1:0] ch_data [N_CH];

  always #5 i_clk = ~i_clk;

  chan_if #(.WIDTH(WIDTH)) u_chan [N_CH-1:0] ();

  for (genvar i = 0; i < N_CH; i++) begin : g_drv
    assign u_chan[i].valid = ch_valid[i];
    assign u_chan[i].data  = ch_data[i];
    assign ch_rdy[i]       = u_chan[i].ready;
  end

  chan_capture_array #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .u_chan  (u_chan),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_chan  (o_chan),
    .o_empty (o_empty)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q [N_CH][$];
  logic m_valid;
  logic [WIDTH-1:0] m_data;
  int m_chan;
  int m_rr;

  function automatic logic [N_CH-1:0] exp_ready();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++)
      r[c] = i_rst_n && !i_flush && (exp_q[c].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_empty();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = (exp_q[c].size() == 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) exp_q[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_rr    = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [N_CH-1:0] acc;
    int c;
    bit hit;
    if (i_flush) begin
      for (int k = 0; k < N_CH; k++) exp_q[k].delete();
      m_valid = 1'b0;
      m_rr    = 0;
      return;
    end
    for (int k = 0; k < N_CH; k++)
      acc[k] = ch_valid[k] && (exp_q[k].size() < DEPTH);
    if (!m_valid || i_ready) begin
      hit = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        c = (m_rr + k) % N_CH;
        if (!hit && exp_q[c].size() > 0) begin
          hit    = 1'b1;
          m_data = exp_q[c].pop_front();
          m_chan = c;
          m_rr   = (c + 1) % N_CH;
        end
      end
      m_valid = hit;
    end
    for (int k = 0; k < N_CH; k++)
      if (acc[k]) exp_q[k].push_back(ch_data[k]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    ch_valid = '0;
    i_flush  = 1'b0;
    for (int c = 0; c < N_CH; c++) ch_data[c] = '0;
  endtask

  task automatic drain();
    idle_inputs();
    i_ready = 1'b1;
    repeat (DEPTH * N_CH + 2) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge i_clk);
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_checks++; if (o_chan !== '0) begin n_errors++; $display("FAIL reset_chan: got %0d expected 0", o_chan); end
    n_checks++; if (o_empty !== '1) begin n_errors++; $display("FAIL reset_empty: got %b expected all ones", o_empty); end
    n_checks++; if (ch_rdy !== '0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", ch_rdy); end
    i_rst_n = 1'b1;
    #1;
    n_checks++; if (ch_rdy !== '1) begin n_errors++; $display("FAIL release_ready: got %b expected all ones", ch_rdy); end
  endtask

  task automatic test_first_push();
    ch_valid    = '0;
    ch_valid[3] = 1'b1;
    ch_data[3]  = 8'hA5;
    tick();
    ch_valid = '0;
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL first_latency: got valid %b expected 0", o_valid); end
    n_checks++; if (o_empty[3] !== 1'b0) begin n_errors++; $display("FAIL first_buffered: got empty3 %b expected 0", o_empty[3]); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL first_valid: got %b expected 1", o_valid); end
    n_checks++; if (o_data !== 8'hA5) begin n_errors++; $display("FAIL first_data: got %h expected a5", o_data); end
    n_checks++; if (o_chan !== 3'd3) begin n_errors++; $display("FAIL first_chan: got %0d expected 3", o_chan); end
    n_checks++; if (o_empty !== exp_empty() || o_empty[3] !== 1'b1) begin n_errors++; $display("FAIL first_empty: got %b expected %b", o_empty, exp_empty()); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL first_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_round_robin();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    for (int c = 0; c < N_CH; c++) ch_data[c] = WIDTH'(c);
    ch_valid = '1;
    tick();
    ch_valid = '0;
    for (int i = 0; i < N_CH; i++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || int'(o_chan) !== i || o_data !== WIDTH'(i)) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: got valid %b chan %0d data %h expected valid 1 chan %0d data %h", i, o_valid, o_chan, o_data, i, WIDTH'(i));
      end
    end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL rr_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_backpressure();
    logic exp_r;
    i_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      ch_data[0]  = WIDTH'(n);
      ch_valid[0] = 1'b1;
      #1;
      exp_r = (n < 5);
      n_checks++;
      if (ch_rdy[0] !== exp_r || ch_rdy[0] !== exp_ready()[0]) begin
        n_errors++;
        $display("FAIL bp_ready[%0d]: got %b expected %b", n, ch_rdy[0], exp_r);
      end
      tick();
    end
    ch_valid = '0;
    i_ready  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== WIDTH'(j) || o_chan !== '0) begin
        n_errors++;
        $display("FAIL bp_order[%0d]: got valid %b data %h chan %0d expected valid 1 data %h chan 0", j, o_valid, o_data, o_chan, WIDTH'(j));
      end
      tick();
    end
    n_checks++; if (o_valid !== 1'b0 || o_empty[0] !== 1'b1) begin n_errors++; $display("FAIL bp_no_extra: got valid %b empty0 %b expected 0 1", o_valid, o_empty[0]); end
  endtask

  task automatic test_fairness();
    int grants;
    bit seen;
    i_ready     = 1'b1;
    ch_valid[0] = 1'b1;
    repeat (3) begin
      ch_data[0] = WIDTH'($urandom);
      tick();
    end
    ch_data[0]  = WIDTH'($urandom);
    ch_valid[5] = 1'b1;
    ch_data[5]  = 8'h5A;
    tick();
    ch_valid[5] = 1'b0;
    grants = 0;
    seen   = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      ch_data[0] = WIDTH'($urandom);
      tick();
      n_checks++;
      if (o_valid !== m_valid || (m_valid && int'(o_chan) !== m_chan)) begin
        n_errors++;
        $display("FAIL fair_model: got valid %b chan %0d expected valid %b chan %0d", o_valid, o_chan, m_valid, m_chan);
      end
      if (o_valid === 1'b1) begin
        if (o_chan === 3'd5) begin
          seen = 1'b1;
          n_checks++; if (o_data !== 8'h5A) begin n_errors++; $display("FAIL fair_data: got %h expected 5a", o_data); end
        end else begin
          grants++;
        end
      end
    end
    n_checks++;
    if (!seen || grants > 2) begin
      n_errors++;
      $display("FAIL fair_bound: got seen %0d after %0d other grants expected seen 1 within 2", seen, grants);
    end
    drain();
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      ch_valid[2] = 1'b1;
      ch_data[2]  = WIDTH'(8'h20 + n);
      tick();
    end
    n_checks++; if (o_valid !== 1'b1 || o_empty[2] !== 1'b0) begin n_errors++; $display("FAIL flush_setup: got valid %b empty2 %b expected 1 0", o_valid, o_empty[2]); end
    i_flush    = 1'b1;
    ch_data[2] = 8'h11;
    #1;
    n_checks++; if (ch_rdy[2] !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", ch_rdy[2]); end
    tick();
    i_flush  = 1'b0;
    ch_valid = '0;
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_empty !== '1) begin n_errors++; $display("FAIL flush_empty: got %b expected all ones", o_empty); end
    i_ready = 1'b1;
    tick();
    n_checks++; if (o_valid !== 1'b0 || o_empty[2] !== 1'b1) begin n_errors++; $display("FAIL flush_dropped: got valid %b empty2 %b expected 0 1", o_valid, o_empty[2]); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < N_CH; c++) begin
        ch_valid[c] = ($urandom_range(0, 2) == 0);
        ch_data[c]  = WIDTH'($urandom);
      end
      #1;
      n_checks++;
      if (ch_rdy !== exp_ready()) begin
        n_errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, ch_rdy, exp_ready());
      end
      tick();
      n_checks++;
      if (o_valid !== m_valid) begin
        n_errors++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, o_valid, m_valid);
      end else if (m_valid && (o_data !== m_data || int'(o_chan) !== m_chan)) begin
        n_errors++;
        $display("FAIL rand_word[%0d]: got chan %0d data %h expected chan %0d data %h", cyc, o_chan, o_data, m_chan, m_data);
      end
      n_checks++;
      if (o_empty !== exp_empty()) begin
        n_errors++;
        $display("FAIL rand_empty[%0d]: got %b expected %b", cyc, o_empty, exp_empty());
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    i_ready     = 1'b0;
    ch_valid[1] = 1'b1;
    ch_data[1]  = 8'h3C;
    tick();
    ch_valid = '0;
    tick();
    n_checks++; if (o_valid !== 1'b1 || o_data !== 8'h3C) begin n_errors++; $display("FAIL areset_setup: got valid %b data %h expected 1 3c", o_valid, o_data); end
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL areset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_data !== '0 || o_chan !== '0) begin n_errors++; $display("FAIL areset_word: got data %h chan %0d expected 00 0", o_data, o_chan); end
    n_checks++; if (o_empty !== '1 || ch_rdy !== '0) begin n_errors++; $display("FAIL areset_flags: got empty %b ready %b expected all ones and 0", o_empty, ch_rdy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    n_checks++; if (ch_rdy !== '1) begin n_errors++; $display("FAIL areset_release: got %b expected all ones", ch_rdy); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL areset_after: got %b expected 0", o_valid); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_first_push();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chan_capture_array.md
# chan_capture_array

Parametrised, buffered successor to the per-channel interface-array capture pattern. It takes `N_CH` channel interfaces, with one interface instance per array element. Each channel is buffered in its own FIFO, and all channels are merged onto a single registered valid/ready output stream through a round-robin arbiter. It sits between an array of producer interfaces and one downstream consumer.

## Interface
- `N_CH`, 8: number of channel interfaces; must be ≥ 2.
- `WIDTH`, 8: data width per channel, in bits.
- `DEPTH`, 4: entries per channel FIFO; must be a power of two, ≥ 2.
- `i_clk`  input  1: single clock; all state updates on its rising edge.
- `i_rst_n`  input  1: reset, asynchronous and active-low.
- `u_chan`  interface array  `[N_CH-1:0]`: `chan_if.sink` modport.
  - Producer drives `valid` and `data[WIDTH-1:0]`.
  - This block drives `ready`.
- `i_flush`  input  1: synchronous clear of all buffered data.
- `o_valid`  output  1: output word available.
- `i_ready`  input  1: consumer accepts the word.
- `o_data`  output  `WIDTH`: output word.
- `o_chan`  output  `$clog2(N_CH)`: index of the source channel for `o_data`.
- `o_empty`  output  `N_CH`: per-channel FIFO empty flag.

## Operation
- **Channel push:** channel `c` pushes when `u_chan[c].valid && u_chan[c].ready`.
- **Ready:** `u_chan[c].ready = !full[c] && !i_flush`, taken from registered count only.
  - There is no combinational path from pop to ready.
  - A full FIFO therefore refuses a push even in a cycle when it pops.
- **FIFO:** per-channel circular buffer with read and write pointers of `$clog2(DEPTH)` bits, wrapping at `DEPTH`.
  - Count is `$clog2(DEPTH)+1` bits.
  - `full = (count == DEPTH)`, `empty = (count == 0)`.
- **Output register:** one stage holding `o_valid`, `o_data`, `o_chan`.
  - Load is enabled when `!o_valid || i_ready`.
- **Arbitration:** when load is enabled, pick the first non-empty channel at or after pointer `rr`, scanning upward and wrapping mod `N_CH`.
  - Pop that channel's FIFO and load its word and index.
  - Set `rr = winner + 1`, wrapping to 0 after `N_CH-1`.
  - If no channel is non-empty, `o_valid` goes to 0 on a load cycle.
- **Output stability:** while `o_valid && !i_ready`, `o_data` and `o_chan` hold stable and no FIFO pops.
- **Same-channel push and pop:** push and pop on one channel in the same cycle leave count unchanged.
- **Flush:** `i_flush` high at a clock edge clears all of the following:
  - all counts and pointers;
  - `o_valid`;
  - `rr` to 0.

  Any push offered in that cycle is not accepted (ready is low). Flush takes priority over every push and pop.
- **Reset:** asserting `i_rst_n` low has the same effect as flush, applied asynchronously, at any time, including mid-transfer.
- **Reset values:**
  - `o_valid = 0`
  - `o_data = '0`
  - `o_chan = 0`
  - `o_empty = '1`
  - all `ready = 0` while in reset, then 1 from the first cycle after reset release.

## Timing
- **Latency:** a word pushed at edge k can appear on `o_valid`/`o_data` after edge k+1 at the earliest.
- **Throughput:** one word per cycle aggregate while `i_ready` stays high and any FIFO is non-empty.
- **Fairness:** a continuously non-empty channel waits at most `N_CH-1` grants.
- **`o_empty`:** reflects registered count, updated on the same edge as the push or pop.
- **Reset release:** the first push is possible on the first rising edge after `i_rst_n` rises.

## Structure
- **Package `chan_pkg`:**
  - `localparam int N_CH_DEFAULT`, `WIDTH_DEFAULT`, `DEPTH_DEFAULT`;
  - `typedef logic [$clog2(N_CH_DEFAULT)-1:0] chan_idx_t`.
- **Interface `chan_if #(WIDTH)`:** declares `valid`, `ready`, `data` with modports `source` and `sink`.
- **Sub-module `chan_fifo #(WIDTH, DEPTH)`:** one FIFO, instantiated `N_CH` times by a generate loop indexed into `u_chan[i]`.
- **Top level:** the arbiter and output register live in `chan_capture_array`.
- **Timescale:** `timeunit 1ns; timeprecision 1ps;` is declared exactly once in every module and interface.

## Test plan
- **Reset and first push:** hold reset, release, then push `0xA5` on channel 3 alone.
  - Expect `o_valid=1`, `o_data=0xA5`, `o_chan=3` one edge after the push.
  - Expect `o_empty[3]` back to 1.
- **Round robin:** all 8 channels push `data=c` simultaneously with `i_ready=1`.
  - Expect `o_chan` sequence 0,1,2,…,7 on consecutive cycles, each `o_data` equal to `o_chan`.
- **Backpressure and full:** hold `i_ready=0` and push 6 words on channel 0 (`DEPTH=4`).
  - Expect `ready` low after 4 FIFO entries plus 1 in the output register.
  - Then release `i_ready` and expect words 0..4 out in order, with none lost or duplicated.
- **Fairness under load:** channel 0 valid every cycle while channel 5 pushes one word.
  - Expect channel 5 granted within 2 grants.
- **Flush mid-stream:** with 3 words buffered on channel 2 and `o_valid=1`, pulse `i_flush` while channel 2 offers `0x11`.
  - Expect `o_valid=0`, all `o_empty=1`, and `0x11` not accepted.
- **Async reset mid-transfer:** assert `i_rst_n` between clock edges with `o_valid=1`.
  - Expect `o_valid=0` immediately, before the next edge.
  - Expect all outputs at their reset values.
